// File: rtl/kamacore_pkg.sv
// Shared kamacore types and constants used by pipeline and perf-counter blocks.
package kamacore_pkg;

  localparam int unsigned CPU_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } stage_state_e;

endpackage

// File: rtl/kamacore_sat_counter.sv
// Saturating up-counter with synchronous clear; shared by kamacore perf counters.
module kamacore_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/kamacore_pipeline_elastic.sv
// Elastic valid/ready pipeline register between kamacore stages, with optional
// skid entry, hold/flush control and a saturating back-pressure counter.
module kamacore_pipeline_elastic
  import kamacore_pkg::*;
#(
  parameter int unsigned WIDTH     = CPU_WIDTH,
  parameter int unsigned SKID      = 1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 stat_clr,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  stage_state_e     state_q;
  stage_state_e     state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_data;
  logic             in_fire;
  logic             out_fire;
  logic             load_main_in;
  logic             load_main_skid;
  logic             stall;

  // Ready is gated by reset so upstream sees no acceptance while rst is low.
  always_comb begin
    if (SKID != 0) begin
      in_ready = rst & ~hold & (state_q != ST_TWO);
    end else begin
      in_ready = rst & ~hold & ((state_q == ST_EMPTY) | out_ready);
    end
    out_valid = ~hold & (state_q != ST_EMPTY);
    out_data  = main_q;
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d      = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire && (SKID != 0)) begin
            state_d = ST_TWO;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d        = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
    end else if (load_main_in) begin
      main_q <= in_data;
    end else if (load_main_skid) begin
      main_q <= skid_data;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [WIDTH-1:0] skid_q;
      logic             load_skid;

      // Second beat arrives while the main entry is still back-pressured.
      assign load_skid = ~flush & (state_q == ST_ONE) & in_fire & ~out_fire;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          skid_q <= '0;
        end else if (load_skid) begin
          skid_q <= in_data;
        end
      end

      assign skid_data = skid_q;
    end else begin : g_no_skid
      assign skid_data = '0;
    end
  endgenerate

  assign stall = (state_q != ST_EMPTY) & ~hold & ~out_ready;

  kamacore_sat_counter #(
    .W (CNT_WIDTH)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall),
    .clr (stat_clr),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_kamacore_pipeline_elastic.sv
// Scoreboard bench: instance a (SKID=1, 16-bit counter), instance b (SKID=0, 2-bit counter).
module tb_kamacore_pipeline_elastic;
  import kamacore_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned passes = 0;
  int unsigned total  = 0;

  logic         a_rst, a_hold, a_flush, a_in_valid, a_in_ready;
  logic         a_out_valid, a_out_ready, a_stat_clr;
  logic [W-1:0] a_in_data, a_out_data;
  logic [15:0]  a_stall_cnt;
  logic [W-1:0] a_q[$];

  logic         b_rst, b_hold, b_flush, b_in_valid, b_in_ready;
  logic         b_out_valid, b_out_ready, b_stat_clr;
  logic [W-1:0] b_in_data, b_out_data;
  logic [1:0]   b_stall_cnt;
  logic [W-1:0] b_q[$];

  kamacore_pipeline_elastic #(.WIDTH(W), .SKID(1), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(a_rst), .hold(a_hold), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .stat_clr(a_stat_clr), .stall_cnt(a_stall_cnt)
  );

  kamacore_pipeline_elastic #(.WIDTH(W), .SKID(0), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(b_rst), .hold(b_hold), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .stat_clr(b_stat_clr), .stall_cnt(b_stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Monitors: every downstream transfer must match the oldest accepted beat.
  always @(negedge clk) begin
    if (a_rst && a_out_valid && a_out_ready) begin
      if (a_q.size() == 0) begin
        total++;
        $display("FAIL a_extra_beat: got 0x%0h, required no beat", a_out_data);
      end else begin
        check("a_out_data", a_out_data, a_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (b_rst && b_out_valid && b_out_ready) begin
      if (b_q.size() == 0) begin
        total++;
        $display("FAIL b_extra_beat: got 0x%0h, required no beat", b_out_data);
      end else begin
        check("b_out_data", b_out_data, b_q.pop_front());
      end
    end
  end

  task automatic step_a(input logic v, input logic [W-1:0] d, input logic ordy,
                        input logic hld, input logic fl, input logic clr);
    @(posedge clk); #1;
    a_in_valid = v; a_in_data = d; a_out_ready = ordy;
    a_hold = hld; a_flush = fl; a_stat_clr = clr;
    @(negedge clk);
    if (fl) a_q.delete();
    else if (a_in_valid && a_in_ready) a_q.push_back(d);
  endtask

  task automatic step_b(input logic v, input logic [W-1:0] d, input logic ordy,
                        input logic hld, input logic fl, input logic clr);
    @(posedge clk); #1;
    b_in_valid = v; b_in_data = d; b_out_ready = ordy;
    b_hold = hld; b_flush = fl; b_stat_clr = clr;
    @(negedge clk);
    if (fl) b_q.delete();
    else if (b_in_valid && b_in_ready) b_q.push_back(d);
  endtask

  logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  int unsigned k;

  initial begin
    a_rst = 0; a_hold = 0; a_flush = 0; a_in_valid = 0; a_in_data = '0;
    a_out_ready = 0; a_stat_clr = 0;
    b_rst = 0; b_hold = 0; b_flush = 0; b_in_valid = 0; b_in_data = '0;
    b_out_ready = 0; b_stat_clr = 0;

    #3;
    check("reset_in_ready",  a_in_ready,  0);
    check("reset_out_valid", a_out_valid, 0);
    check("reset_out_data",  a_out_data,  0);
    check("reset_stall_cnt", a_stall_cnt, 0);
    @(posedge clk); #1;
    a_rst = 1; b_rst = 1;

    // Streaming 1..8 back-to-back
    for (int i = 1; i <= 8; i++) begin
      step_a(1, W'(i), 1, 0, 0, 0);
      check("stream_in_ready", a_in_ready, 1);
      check("stream_out_valid", a_out_valid, (i > 1) ? 32'd1 : 32'd0);
    end
    step_a(0, '0, 1, 0, 0, 0);
    check("stream_last_valid", a_out_valid, 1);
    step_a(0, '0, 1, 0, 0, 0);
    check("stream_drained", a_out_valid, 0);
    check("stream_stall_cnt", a_stall_cnt, 0);

    // Back-pressure: A, B, C with three stalled cycles
    step_a(1, 32'hA, 1, 0, 0, 0);
    step_a(1, 32'hB, 0, 0, 0, 0);
    check("bp_ready_one", a_in_ready, 1);
    check("bp_data_a", a_out_data, 32'hA);
    step_a(1, 32'hC, 0, 0, 0, 0);
    check("bp_ready_two", a_in_ready, 0);
    check("bp_data_a_held", a_out_data, 32'hA);
    step_a(1, 32'hC, 0, 0, 0, 0);
    check("bp_ready_two_b", a_in_ready, 0);
    step_a(1, 32'hC, 1, 0, 0, 0);
    check("bp_stall_cnt", a_stall_cnt, 3);
    check("bp_ready_release", a_in_ready, 0);
    step_a(1, 32'hC, 1, 0, 0, 0);
    check("bp_ready_after", a_in_ready, 1);
    step_a(0, '0, 1, 0, 0, 0);
    step_a(0, '0, 1, 0, 0, 0);
    check("bp_drained", a_out_valid, 0);
    check("bp_stall_final", a_stall_cnt, 3);

    // Flush while in TWO, concurrent with stat_clr
    step_a(1, 32'h11, 0, 0, 0, 0);
    step_a(1, 32'h12, 0, 0, 0, 0);
    step_a(1, 32'hD, 0, 0, 1, 1);
    check("flush_ready_two", a_in_ready, 0);
    step_a(0, '0, 1, 0, 0, 0);
    check("flush_out_valid", a_out_valid, 0);
    check("flush_stat_clr", a_stall_cnt, 0);
    step_a(1, 32'h33, 1, 0, 0, 0);
    step_a(0, '0, 1, 0, 0, 0);
    check("flush_next_valid", a_out_valid, 1);
    step_a(0, '0, 1, 0, 0, 0);

    // Hold with entries held, then async reset mid-cycle
    step_a(1, 32'h21, 0, 0, 0, 0);
    step_a(1, 32'h22, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step_a(1, 32'h23, 1, 1, 0, 0);
      check("hold_in_ready", a_in_ready, 0);
      check("hold_out_valid", a_out_valid, 0);
      check("hold_out_data", a_out_data, 32'h21);
    end
    #2 a_rst = 0;
    #1;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_stall_cnt", a_stall_cnt, 0);
    check("rst_in_ready", a_in_ready, 0);
    a_q.delete();
    a_in_valid = 0; a_hold = 0;
    @(posedge clk); #1;
    a_rst = 1;
    step_a(1, 32'h44, 1, 0, 0, 0);
    check("rst_release_ready", a_in_ready, 1);
    step_a(0, '0, 1, 0, 0, 0);
    check("rst_release_valid", a_out_valid, 1);
    step_a(0, '0, 1, 0, 0, 0);

    // SKID=0: out_ready toggles under continuous input
    k = 0;
    for (int i = 0; i < 10; i++) begin
      step_b(1, 32'h40 + W'(k), logic'(i % 2), 0, 0, 0);
      check("b_in_ready", b_in_ready, (i == 0) ? 32'd1 : 32'(i % 2));
      if (b_in_valid && b_in_ready) k++;
    end
    step_b(0, '0, 1, 0, 0, 0);
    step_b(0, '0, 1, 0, 0, 0);
    check("b_drained", b_out_valid, 0);

    // Counter saturation at CNT_WIDTH=2
    step_b(1, 32'h55, 0, 0, 0, 1);
    step_b(0, '0, 0, 0, 0, 0);
    check("sat_start", b_stall_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      step_b(0, '0, 0, 0, 0, 0);
      check("sat_cnt", b_stall_cnt, sat_exp[i]);
    end
    step_b(0, '0, 0, 0, 0, 1);
    step_b(0, '0, 1, 0, 0, 0);
    check("sat_clr", b_stall_cnt, 0);
    step_b(0, '0, 1, 0, 0, 0);

    check("a_queue_empty", a_q.size(), 0);
    check("b_queue_empty", b_q.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
